// File: rtl/rx_char_fifo_if.sv
// ---------------------------------------------------------------------------
// rx_char_fifo_if
//   Groups the character-FIFO signals between the serial receiver and the
//   microprocessor side into one bundle.
//
//   Signals
//     data_in             8   character from the serial receiver
//     character_received  1   receiver strobe, asynchronous to clk
//     rd_en               1   single-cycle pop request
//     clr_ovf             1   single-cycle overflow clear
//     data_out            8   head entry (first-word fall-through)
//     empty               1   no entries stored
//     full                1   DEPTH entries stored
//     count               log2(DEPTH)+1  stored entry count
//     overflow            1   sticky: a character was dropped
//
//   Modports
//     master  : the side that drives the inputs (receiver + CPU, or a bench)
//     slave   : the FIFO itself
// ---------------------------------------------------------------------------
interface rx_char_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    data_in;
  logic          character_received;
  logic          rd_en;
  logic          clr_ovf;
  logic [7:0]    data_out;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output data_in,
    output character_received,
    output rd_en,
    output clr_ovf,
    input  data_out,
    input  empty,
    input  full,
    input  count,
    input  overflow
  );

  modport slave (
    input  data_in,
    input  character_received,
    input  rd_en,
    input  clr_ovf,
    output data_out,
    output empty,
    output full,
    output count,
    output overflow
  );
endinterface

// File: rtl/rx_char_fifo.sv
// ---------------------------------------------------------------------------
// rx_char_fifo
//   Receive-character FIFO sitting between a serial receiver running on a
//   divided clock and a microprocessor on clk. The receiver strobe is
//   synchronized into clk, edge-detected so that one rising edge yields
//   exactly one write, and the character is stored in a DEPTH-entry
//   first-word fall-through buffer. Writes into a full FIFO (without a
//   simultaneous pop) are dropped and raise a sticky overflow flag.
//
//   Parameters
//     DEPTH        number of entries, power of two, >= 2
//     SYNC_STAGES  synchronizer flops on character_received, >= 2
//
//   Ports
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   rx_char_fifo_if.slave (see interface header for signal list)
//
//   Write latency: an entry is visible on data_out SYNC_STAGES+1 clk edges
//   after character_received rises.
// ---------------------------------------------------------------------------
module rx_char_fifo #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  rx_char_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // -------------------------------------------------------------------------
  // Strobe synchronizer and rising-edge detector
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   strobe_sync;
  logic                   wr_event;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; a blocking assignment here
  // would collapse the synchronizer chain into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.character_received};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe_sync = sync_q[SYNC_STAGES-1];
  // One write per rising edge, however long the strobe is held high.
  assign wr_event    = strobe_sync & ~edge_q;

  // -------------------------------------------------------------------------
  // Pointer / count state
  // -------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;

  logic          empty_w;
  logic          full_w;
  logic          do_pop;
  logic          do_write;
  logic          drop;

  // Flags decode only registered state, never this cycle's inputs.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // A pop on an empty FIFO is ignored. A write into a full FIFO only
  // proceeds when a pop frees the head slot at the same edge.
  assign do_pop   = bus.rd_en & ~empty_w;
  assign do_write = wr_event & (~full_w | do_pop);
  assign drop     = wr_event & full_w & ~do_pop;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // DEPTH is a power of two, so plain AW-bit increments wrap modulo DEPTH.
    if (do_write) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)   rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({do_write, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set wins over clear when a drop and clr_ovf coincide.
    if (drop)             overflow_d = 1'b1;
    else if (bus.clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // -------------------------------------------------------------------------
  // Entry storage
  // -------------------------------------------------------------------------
  logic [7:0] mem_q [DEPTH];

  // NOTE: storage is deliberately left out of reset; the count and pointers
  // already mark every entry invalid, and an unreset array maps onto plain
  // RAM/flops without a reset fan-out to every bit.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= bus.data_in;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // First-word fall-through: the head is read combinationally from storage;
  // while empty the output is forced to zero so stale data never shows.
  assign bus.data_out = empty_w ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_rx_char_fifo.sv
// ---------------------------------------------------------------------------
// tb_rx_char_fifo
//   Self-checking bench for rx_char_fifo (DEPTH=8, SYNC_STAGES=2).
//   Accepted characters are pushed onto a scoreboard queue when driven and
//   popped/compared when read back. Inputs change and outputs are sampled on
//   the falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_rx_char_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;

  rx_char_fifo_if #(.DEPTH(DEPTH)) bus ();

  rx_char_fifo #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [$];

  typedef struct {
    logic [7:0]    data;
    logic          accept;
    logic [CW-1:0] exp_count;
    logic          exp_full;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one character strobe. The write-event cycle is the one between the
  // 2nd and 3rd rising edges; rd_en / clr_ovf can be asserted exactly there.
  task automatic send_char(input logic [7:0] d, input logic pop_ev,
                           input logic clr_ev, input int hold);
    logic [7:0] exp;
    bus.data_in            = d;
    bus.character_received = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (pop_ev) begin
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("pop_in_event_data", {24'h0, bus.data_out}, {24'h0, exp});
      end
      bus.rd_en = 1'b1;
    end
    if (clr_ev) bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    repeat (hold) @(negedge clk);
    bus.character_received = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_check();
    logic [7:0] exp;
    if (sb.size() == 0) begin
      check("pop_scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      check("pop_data", {24'h0, bus.data_out}, {24'h0, exp});
      check("pop_not_empty", {31'h0, bus.empty}, 32'd0);
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 9; i++) begin
      vecs[i].data      = 8'(i + 1);
      vecs[i].accept    = (i < DEPTH);
      vecs[i].exp_count = (i < DEPTH) ? CW'(i + 1) : CW'(DEPTH);
      vecs[i].exp_full  = (i >= DEPTH - 1);
      vecs[i].exp_ovf   = (i == DEPTH);
    end

    rst                    = 1'b1;
    bus.data_in            = 8'h00;
    bus.character_received = 1'b0;
    bus.rd_en              = 1'b0;
    bus.clr_ovf            = 1'b0;
    #1;
    check("reset_count",    {28'h0, bus.count},    32'd0);
    check("reset_empty",    {31'h0, bus.empty},    32'd1);
    check("reset_full",     {31'h0, bus.full},     32'd0);
    check("reset_overflow", {31'h0, bus.overflow}, 32'd0);
    check("reset_data_out", {24'h0, bus.data_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single character, strobe held 40 cycles: latency and one-write-only.
    bus.data_in            = 8'hA5;
    bus.character_received = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("single_before_3rd_edge_empty", {31'h0, bus.empty}, 32'd1);
    @(negedge clk);
    check("single_3rd_edge_data",  {24'h0, bus.data_out}, 32'hA5);
    check("single_3rd_edge_empty", {31'h0, bus.empty},    32'd0);
    check("single_3rd_edge_count", {28'h0, bus.count},    32'd1);
    repeat (37) @(negedge clk);
    bus.character_received = 1'b0;
    repeat (4) @(negedge clk);
    check("single_long_strobe_count", {28'h0, bus.count}, 32'd1);
    sb.push_back(8'hA5);
    pop_check();
    check("single_after_pop_empty", {31'h0, bus.empty},    32'd1);
    check("single_after_pop_data",  {24'h0, bus.data_out}, 32'h0);

    // Write and rd_en together while empty: pop ignored, count becomes 1.
    send_char(8'h3E, 1'b1, 1'b0, 1);
    sb.push_back(8'h3E);
    check("empty_wr_rd_count", {28'h0, bus.count}, 32'd1);
    pop_check();

    // Wrap-around: 20 write/read pairs.
    for (int i = 0; i < 20; i++) begin
      send_char(8'(8'h10 + i), 1'b0, 1'b0, 1);
      sb.push_back(8'(8'h10 + i));
      check("wrap_count_after_write", {28'h0, bus.count}, 32'd1);
      pop_check();
      check("wrap_count_after_pop", {28'h0, bus.count}, 32'd0);
    end

    // Fill and overflow, table-driven.
    for (int i = 0; i < 9; i++) begin
      send_char(vecs[i].data, 1'b0, 1'b0, 1);
      if (vecs[i].accept) sb.push_back(vecs[i].data);
      check("fill_count",    {28'h0, bus.count},    {28'h0, vecs[i].exp_count});
      check("fill_full",     {31'h0, bus.full},     {31'h0, vecs[i].exp_full});
      check("fill_overflow", {31'h0, bus.overflow}, {31'h0, vecs[i].exp_ovf});
    end

    // clr_ovf in the same cycle as another drop: set wins.
    send_char(8'hEE, 1'b0, 1'b1, 1);
    check("prio_overflow_held", {31'h0, bus.overflow}, 32'd1);
    check("prio_count",         {28'h0, bus.count},    32'd8);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    check("lone_clr_overflow", {31'h0, bus.overflow}, 32'd0);

    // Full with pop in the write-event cycle: both happen, no overflow.
    send_char(8'h55, 1'b1, 1'b0, 1);
    sb.push_back(8'h55);
    check("full_pop_count",    {28'h0, bus.count},    32'd8);
    check("full_pop_overflow", {31'h0, bus.overflow}, 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_check();
    check("drain_empty", {31'h0, bus.empty},    32'd1);
    check("drain_data",  {24'h0, bus.data_out}, 32'h0);

    // Strobe already high when reset releases: exactly one write.
    @(negedge clk);
    rst                    = 1'b1;
    bus.data_in            = 8'h3C;
    bus.character_received = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("strobe_at_release_count", {28'h0, bus.count},    32'd1);
    check("strobe_at_release_data",  {24'h0, bus.data_out}, 32'h3C);
    repeat (10) @(negedge clk);
    bus.character_received = 1'b0;
    repeat (4) @(negedge clk);
    check("strobe_at_release_once", {28'h0, bus.count}, 32'd1);
    sb.push_back(8'h3C);
    pop_check();

    // Reset mid-operation: 3 entries, overflow set, strobe in flight.
    for (int i = 0; i < 9; i++) begin
      send_char(8'(8'hC0 + i), 1'b0, 1'b0, 1);
      if (i < DEPTH) sb.push_back(8'(8'hC0 + i));
    end
    for (int i = 0; i < 5; i++) pop_check();
    check("pre_reset_count",    {28'h0, bus.count},    32'd3);
    check("pre_reset_overflow", {31'h0, bus.overflow}, 32'd1);
    bus.data_in            = 8'h99;
    bus.character_received = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_reset_count",    {28'h0, bus.count},    32'd0);
    check("mid_reset_empty",    {31'h0, bus.empty},    32'd1);
    check("mid_reset_overflow", {31'h0, bus.overflow}, 32'd0);
    check("mid_reset_data",     {24'h0, bus.data_out}, 32'h0);
    bus.character_received = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_no_write_count", {28'h0, bus.count}, 32'd0);
    check("post_reset_no_write_empty", {31'h0, bus.empty}, 32'd1);

    // FIFO still usable after the reset.
    send_char(8'h77, 1'b0, 1'b0, 1);
    sb.push_back(8'h77);
    check("post_reset_write_count", {28'h0, bus.count}, 32'd1);
    pop_check();
    check("post_reset_final_empty", {31'h0, bus.empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_char_fifo.md
RX_CHAR_FIFO -- requirements
Module: rx_char_fifo

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 8, giving the number of character entries (a power of two, minimum 2).
REQ-002 The block SHALL provide parameter SYNC_STAGES, default 2, giving the synchronizer flop count on character_received (minimum 2).
REQ-003 clk  input  1  system clock (CLOCK_50 domain).
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 data_in  input  8  parallel character from the serial receiver; held stable while character_received is high.
REQ-006 character_received  input  1  receiver strobe, produced in the divided-clock domain and asynchronous to clk.
REQ-007 rd_en  input  1  single-cycle pop request from the microprocessor side.
REQ-008 clr_ovf  input  1  single-cycle clear of the overflow flag.
REQ-009 data_out  output  8  head entry (first-word fall-through).
REQ-010 empty  output  1  high when count == 0.
REQ-011 full  output  1  high when count == DEPTH.
REQ-012 count  output  log2(DEPTH)+1  number of stored entries.
REQ-013 overflow  output  1  sticky flag; a character was dropped.

Function
REQ-014 The block SHALL pass character_received through a SYNC_STAGES flop chain, then one further edge-detect flop; a write event SHALL be the cycle where the synchronized value is 1 and the edge-detect flop holds 0.
REQ-015 On a write event the block SHALL capture data_in in that same cycle; one write SHALL occur per rising edge of character_received, regardless of how long the strobe stays high.
REQ-016 Write latency: the entry SHALL be visible on data_out, with empty low, SYNC_STAGES+1 clk edges after character_received rises (3 edges at the default setting).
REQ-017 When empty is low, data_out SHALL show the oldest entry combinationally from storage; when empty is high, data_out SHALL be 8'h00.
REQ-018 A pop SHALL occur when rd_en=1 and empty=0; it SHALL advance the read pointer at that edge so that the next entry appears the following cycle.
REQ-019 rd_en while empty SHALL be ignored: no pointer change, no flag change.
REQ-020 Write with full=1 and no pop in the same cycle: the character SHALL be dropped, storage and count SHALL be unchanged, and overflow SHALL be set at that edge.
REQ-021 Write and pop in the same cycle with full=1: both SHALL occur, count SHALL be unchanged, and overflow SHALL stay unchanged.
REQ-022 Write and rd_en in the same cycle with empty=1: the write SHALL occur, the pop SHALL be ignored, and count SHALL become 1.
REQ-023 Write and pop in the same cycle otherwise: both SHALL occur, and count SHALL be unchanged.
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-025 clr_ovf SHALL clear overflow at the next edge; if an overflow drop occurs in the same cycle, set SHALL take priority.
REQ-026 full, empty and count SHALL be registered values, or values decoded from registered state with no dependence on the current cycle's inputs.

Reset
REQ-027 rst high SHALL, asynchronously: clear both pointers and count to 0, force empty=1, full=0 and overflow=0, force data_out to 8'h00, and clear all synchronizer and edge-detect flops to 0.
REQ-028 Stored entry contents need not be cleared on reset.
REQ-029 If character_received is already high when rst deasserts, it SHALL produce one write after synchronization; the design accepts this and the bench checks for it.
REQ-030 Reset asserted mid-operation SHALL discard all entries and any in-flight synchronizer edge; no write SHALL occur from an edge that was in the chain when rst asserted.

Verification
REQ-031 Single character: after reset, data_in=8'hA5 and character_received pulses high for 40 clk. Required: exactly one entry; data_out=8'hA5, empty=0 and count=1 on the 3rd edge after the rise; rd_en for one cycle then gives empty=1 and data_out=8'h00.
REQ-032 Fill and overflow: write 9 characters 8'h01..8'h09 with no reads. Required: full=1 and count=8 after the 8th; the 9th is dropped and overflow=1; 8 pops return 8'h01..8'h08 in order.
REQ-033 Full with simultaneous pop: FIFO full, and rd_en asserted in the write-event cycle for 8'h55. Required: count stays 8, overflow stays 0, and 8'h55 is returned last.
REQ-034 Wrap-around: run 20 write/read pairs with data 8'h10..8'h23. Required: every value is read back in order and count never exceeds 1.
REQ-035 Flag priority: overflow=1, then clr_ovf asserted in the same cycle as another dropped write. Required: overflow stays 1; a later lone clr_ovf pulse gives overflow=0.
REQ-036 Reset mid-operation: 3 entries stored and a strobe rising, then rst pulsed for 2 cycles. Required: count=0, empty=1 and overflow=0 immediately, and no write appears after rst releases.
